// File: rtl/sa_buf_pkg.sv
// Shared types and defaults for the systolic-array edge buffer: FSM state
// encoding, a width helper and the default geometry used by the array top.
package sa_buf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } sa_state_e;

    localparam int SA_WIDTH = 8;
    localparam int SA_LANES = 4;
    localparam int SA_DEPTH = 16;

    // Smallest w with 2**w >= value; 0 for value <= 1.
    function automatic int sa_clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/buf_lane_fifo.sv
// One lane of the skewed input buffer: circular FIFO with occupancy count,
// registered full/empty and sticky underflow/overflow flags.
module buf_lane_fifo
    import sa_buf_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH,
    parameter int DEPTH = SA_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    input  logic             clr_err,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             underflow,
    output logic             overflow
);

    localparam int AW = sa_clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nx;
    logic             wr_acc;
    logic             wr_drop;
    logic             rd_acc;
    logic             rd_miss;

    // A scheduled pop frees a slot in the same cycle, so a full lane still
    // accepts a write alongside it. An empty lane never bypasses.
    assign wr_acc  = wr_en && (!full || pop);
    assign wr_drop = wr_en && full && !pop;
    assign rd_acc  = pop && !empty;
    assign rd_miss = pop && empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_nx = count;
        if (wr_acc && !rd_acc) begin
            count_nx = count + 1'b1;
        end else if (!wr_acc && rd_acc) begin
            count_nx = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_nx;
            full      <= (count_nx == CW'(DEPTH));
            empty     <= (count_nx == '0);
            // Clear loses against a same-cycle error.
            underflow <= (underflow & ~clr_err) | rd_miss;
            overflow  <= (overflow & ~clr_err) | wr_drop;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/skewed_input_buffer.sv
// Multi-lane edge buffer for a systolic array: per-lane FIFOs drained with a
// diagonal skew (lane i delayed by i cycles), zero-filled outside each window.
module skewed_input_buffer
    import sa_buf_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH,
    parameter int LANES = SA_LANES,
    parameter int DEPTH = SA_DEPTH,
    parameter int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES*WIDTH-1:0] wr_data,
    input  logic [LANES-1:0]       wr_en,
    output logic [LANES-1:0]       full,
    output logic [LANES-1:0]       empty,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
    output logic                   busy,
    output logic                   done,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       valid_out,
    output logic [LANES-1:0]       underflow,
    output logic [LANES-1:0]       overflow,
    input  logic                   clr_err,
    output sa_state_e              fsm_state
);

    // t reaches len+LANES-2 at most; this width holds len+LANES with margin.
    localparam int T_W = LEN_W + sa_clog2(LANES + 1);

    sa_state_e        state;
    sa_state_e        state_nx;
    logic [LEN_W-1:0] len_q;
    logic [T_W-1:0]   t_q;
    logic             launch;
    logic             last_t;
    logic [LANES-1:0] pop;

    assign launch    = (state == IDLE) && start && (len != '0);
    assign last_t    = ({1'b0, t_q} + (T_W+1)'(2)) == ((T_W+1)'(len_q) + (T_W+1)'(LANES));
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (launch) state_nx = STREAM;
            STREAM:  if (last_t) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            STREAM:  busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q <= '0;
            t_q   <= '0;
        end else if (launch) begin
            len_q <= len;
            t_q   <= '0;
        end else if (state == STREAM) begin
            t_q <= t_q + 1'b1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [T_W:0]     win_lo;
        logic [T_W:0]     win_hi;
        logic [WIDTH-1:0] head;
        logic [WIDTH-1:0] dq;
        logic             vq;

        // Lane i pops while i <= t < i+len.
        assign win_lo = (T_W+1)'(i);
        assign win_hi = win_lo + (T_W+1)'(len_q);
        assign pop[i] = (state == STREAM) && ({1'b0, t_q} >= win_lo) && ({1'b0, t_q} < win_hi);

        buf_lane_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (wr_en[i]),
            .wr_data   (wr_data[i*WIDTH +: WIDTH]),
            .pop       (pop[i]),
            .clr_err   (clr_err),
            .head      (head),
            .full      (full[i]),
            .empty     (empty[i]),
            .underflow (underflow[i]),
            .overflow  (overflow[i])
        );

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dq <= '0;
                vq <= 1'b0;
            end else if (pop[i] && !empty[i]) begin
                dq <= head;
                vq <= 1'b1;
            end else begin
                dq <= '0;
                vq <= 1'b0;
            end
        end

        assign data_out[i*WIDTH +: WIDTH] = dq;
        assign valid_out[i]               = vq;
    end

endmodule

// File: tb/tb_skewed_input_buffer.sv
// Directed and randomized bench for skewed_input_buffer (LANES=4, DEPTH=4,
// WIDTH=8) against per-lane queue models of the buffer's behaviour.
module tb_skewed_input_buffer;
    import sa_buf_pkg::*;

    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int DEPTH = 4;
    localparam int LEN_W = $clog2(DEPTH + 1);

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [LANES*WIDTH-1:0] wr_data = '0;
    logic [LANES-1:0]       wr_en = '0;
    logic [LANES-1:0]       full;
    logic [LANES-1:0]       empty;
    logic                   start = 1'b0;
    logic [LEN_W-1:0]       len = '0;
    logic                   busy;
    logic                   done;
    logic [LANES*WIDTH-1:0] data_out;
    logic [LANES-1:0]       valid_out;
    logic [LANES-1:0]       underflow;
    logic [LANES-1:0]       overflow;
    logic                   clr_err = 1'b0;
    sa_state_e              fsm_state;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Reference model: one queue of stored operands per lane.
    logic [WIDTH-1:0] lane_q [LANES][$];
    logic [WIDTH-1:0] exp_dat [LANES];
    logic [LANES-1:0] exp_val;
    logic [LANES-1:0] exp_uf;
    logic [LANES-1:0] exp_of;

    always #5 clk = ~clk;

    skewed_input_buffer #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .full      (full),
        .empty     (empty),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .data_out  (data_out),
        .valid_out (valid_out),
        .underflow (underflow),
        .overflow  (overflow),
        .clr_err   (clr_err),
        .fsm_state (fsm_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) begin
            lane_q[i].delete();
            exp_dat[i] = '0;
        end
        exp_val = '0;
        exp_uf  = '0;
        exp_of  = '0;
    endtask

    task automatic check_status(input string tag);
        logic [LANES-1:0] e_empty;
        logic [LANES-1:0] e_full;
        for (int i = 0; i < LANES; i++) begin
            e_empty[i] = (lane_q[i].size() == 0);
            e_full[i]  = (lane_q[i].size() == DEPTH);
        end
        chk({tag, ".empty"}, empty, e_empty);
        chk({tag, ".full"}, full, e_full);
        chk({tag, ".underflow"}, underflow, exp_uf);
        chk({tag, ".overflow"}, overflow, exp_of);
    endtask

    task automatic check_outputs(input string tag, input logic e_busy, input logic e_done,
                                 input sa_state_e e_state);
        logic [LANES*WIDTH-1:0] e_data;
        for (int i = 0; i < LANES; i++) begin
            e_data[i*WIDTH +: WIDTH] = exp_dat[i];
        end
        chk({tag, ".data_out"}, data_out, e_data);
        chk({tag, ".valid_out"}, valid_out, exp_val);
        chk({tag, ".busy"}, busy, e_busy);
        chk({tag, ".done"}, done, e_done);
        chk({tag, ".state"}, fsm_state, e_state);
        check_status(tag);
    endtask

    // One write cycle outside a stream; called and returns at a falling edge.
    task automatic write_cycle(input logic [LANES-1:0] mask, input logic [LANES*WIDTH-1:0] vals);
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                if (lane_q[i].size() < DEPTH) lane_q[i].push_back(vals[i*WIDTH +: WIDTH]);
                else exp_of[i] = 1'b1;
            end
        end
        wr_en   = mask;
        wr_data = vals;
        @(negedge clk);
        wr_en = '0;
    endtask

    task automatic clear_errors(input string tag);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        exp_uf = '0;
        exp_of = '0;
        check_status(tag);
    endtask

    // Launch a stream of l operands per lane and check every cycle until the
    // FSM is back in IDLE. Optional single write (wr_cyc>0) and a start poke
    // in cycle 3 that must be ignored.
    task automatic run_stream(input string tag, input int l, input int wr_lane, input int wr_cyc,
                              input logic [WIDTH-1:0] wr_val, input bit poke);
        int  t;
        bit  streaming;
        bit  pop_i;
        bit  wr_here;
        bit  acc;
        sa_state_e e_state;
        start = 1'b1;
        len   = l[LEN_W-1:0];
        @(negedge clk);
        start = 1'b0;
        len   = '0;
        for (int i = 0; i < LANES; i++) exp_dat[i] = '0;
        exp_val = '0;
        for (int c = 1; c <= l + LANES + 1; c++) begin
            if (c < l + LANES) e_state = STREAM;
            else if (c == l + LANES) e_state = DONE;
            else e_state = IDLE;
            check_outputs($sformatf("%s.c%0d", tag, c), c <= l + LANES, c == l + LANES, e_state);
            t = c - 1;
            streaming = (c < l + LANES);
            for (int i = 0; i < LANES; i++) begin
                pop_i   = streaming && (t >= i) && (t < i + l);
                wr_here = (c == wr_cyc) && (i == wr_lane);
                acc     = wr_here && ((lane_q[i].size() < DEPTH) || pop_i);
                if (wr_here && !acc) exp_of[i] = 1'b1;
                exp_dat[i] = '0;
                exp_val[i] = 1'b0;
                if (pop_i) begin
                    if (lane_q[i].size() > 0) begin
                        exp_dat[i] = lane_q[i].pop_front();
                        exp_val[i] = 1'b1;
                    end else begin
                        exp_uf[i] = 1'b1;
                    end
                end
                if (acc) lane_q[i].push_back(wr_val);
            end
            wr_en = '0;
            if (c == wr_cyc) begin
                wr_en[wr_lane] = 1'b1;
                wr_data[wr_lane*WIDTH +: WIDTH] = wr_val;
            end
            start = poke && (c == 3);
            len   = (poke && (c == 3)) ? LEN_W'(5) : '0;
            @(negedge clk);
        end
        wr_en = '0;
        start = 1'b0;
        len   = '0;
    endtask

    initial begin
        logic [LANES*WIDTH-1:0] vals;
        logic [LANES-1:0]       mask;
        int                     cnt [LANES];
        int                     l;

        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset_held", 1'b0, 1'b0, IDLE);
        rst = 1'b1;
        @(negedge clk);
        check_outputs("reset_rel", 1'b0, 1'b0, IDLE);

        // Test 1/2: first write to lane 0, then complete the preload and stream len=3.
        vals = '0;
        write_cycle(4'b0001, vals);
        chk("t1.empty_one_write", empty, 4'b1110);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < LANES; i++) vals[i*WIDTH +: WIDTH] = WIDTH'(16*i + k);
            write_cycle((k == 0) ? 4'b1110 : 4'b1111, vals);
        end
        check_status("t2.preload");
        run_stream("t2", 3, 0, 0, '0, 1'b0);
        chk("t2.all_empty", empty, 4'b1111);

        // Test 3: lane 2 holds one operand, others two; len=2.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < LANES; i++) vals[i*WIDTH +: WIDTH] = WIDTH'(16*i + k);
            write_cycle((k == 0) ? 4'b1111 : 4'b1011, vals);
        end
        run_stream("t3", 2, 0, 0, '0, 1'b0);
        chk("t3.underflow", underflow, 4'b0100);
        clear_errors("t3.clr");
        chk("t3.underflow_clr", underflow, 4'b0000);

        // Test 4: five writes to lane 0, fifth dropped.
        for (int k = 0; k < 5; k++) begin
            vals = '0;
            vals[WIDTH-1:0] = WIDTH'($urandom_range(0, 255));
            write_cycle(4'b0001, vals);
            check_status($sformatf("t4.w%0d", k));
            if (k == 3) chk("t4.full_after_4", full[0], 1'b1);
        end
        chk("t4.overflow", overflow[0], 1'b1);
        run_stream("t4", 4, 0, 0, '0, 1'b0);
        clear_errors("t4.clr");

        // Test 5: full lane 1 written during its scheduled pop; ignored starts.
        for (int k = 0; k < DEPTH; k++) begin
            vals = '0;
            vals[WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
            write_cycle(4'b0010, vals);
        end
        chk("t5.full_before", full[1], 1'b1);
        run_stream("t5", 1, 1, 2, WIDTH'($urandom_range(0, 255)), 1'b1);
        chk("t5.full_after", full[1], 1'b1);
        chk("t5.no_overflow", overflow[1], 1'b0);
        start = 1'b1;
        len   = '0;
        @(negedge clk);
        start = 1'b0;
        chk("t5.len0_busy", busy, 1'b0);
        chk("t5.len0_state", fsm_state, IDLE);
        run_stream("t5.drain", 4, 0, 0, '0, 1'b0);
        clear_errors("t5.clr");

        // Test 6: reset during stream cycle t=2.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < LANES; i++) vals[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
            write_cycle(4'b1111, vals);
        end
        start = 1'b1;
        len   = LEN_W'(3);
        @(negedge clk);
        start = 1'b0;
        len   = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        check_outputs("t6.aborted", 1'b0, 1'b0, IDLE);
        repeat (3) begin
            @(negedge clk);
            chk("t6.no_done", done, 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Randomized rounds: fresh preload, stream with one random write, drain.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < LANES; i++) cnt[i] = $urandom_range(0, DEPTH);
            for (int k = 0; k < DEPTH; k++) begin
                for (int i = 0; i < LANES; i++) begin
                    mask[i] = (k < cnt[i]);
                    vals[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
                end
                write_cycle(mask, vals);
            end
            l = $urandom_range(1, 7);
            run_stream($sformatf("rnd%0d", r), l, $urandom_range(0, LANES - 1),
                       $urandom_range(1, l + LANES - 1), WIDTH'($urandom_range(0, 255)), 1'b0);
            run_stream($sformatf("rnd%0d.drain", r), 7, 0, 0, '0, 1'b0);
            clear_errors($sformatf("rnd%0d.clr", r));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
